rx_mac_frame_fifo: RTL
======================

Name: rx_mac_frame_fifo

Overview:
- Store-and-forward receive frame FIFO placed directly downstream of rx_mac, in the rx_mac clock domain.
- Accepts the AXI-Stream byte stream that rx_mac produces.
- Commits a frame only when its last beat arrives with tuser=0 and the whole frame fit in the buffer; bad or oversize frames are rolled back and never reach the consumer.
- Presents only complete, good frames on an AXI-Stream master to the upper stack.

Parameters:
- DATA_WIDTH, 8, tdata width in bits.
- DEPTH, 2048, buffer capacity in beats; power of two, at least 16.
- ADDR_WIDTH, $clog2(DEPTH), address width (derived).

Ports:
- clk  input  1  system clock, shared with rx_mac.
- reset  input  1  asynchronous, active-high reset.
- s_rx_axis_tdata  input  DATA_WIDTH  byte from rx_mac.
- s_rx_axis_tvalid  input  1  beat valid.
- s_rx_axis_tuser  input  1  frame error, sampled on the tlast beat.
- s_rx_axis_tlast  input  1  last beat of frame.
- s_rx_axis_trdy  output  1  ready to rx_mac.
- m_axis_tdata  output  DATA_WIDTH  frame byte to consumer.
- m_axis_tvalid  output  1  output beat valid.
- m_axis_tlast  output  1  last byte of committed frame.
- m_axis_trdy  input  1  consumer ready.
- frame_good  output  1  one-cycle pulse: frame committed.
- frame_bad  output  1  one-cycle pulse: frame dropped because tuser=1.
- frame_overflow  output  1  one-cycle pulse: frame dropped because the buffer filled.

Behaviour:
- Reset values (asynchronous reset):
  - All outputs 0.
  - wr_ptr, commit_ptr, rd_ptr = 0; drop flag cleared.
  - Any partially written frame is discarded; the contents of memory are don't-care.
- Ready:
  - s_rx_axis_trdy = 0 while reset is asserted, 1 from the first clk edge after release.
  - The block never backpressures rx_mac; overflow is handled by dropping the frame.
- Pointers and full:
  - All pointers are ADDR_WIDTH+1 bits.
  - Memory entry = {tlast, tdata}.
  - full = (wr_ptr - rd_ptr) == DEPTH.
  - empty = (rd_ptr == commit_ptr).
- Write side (beat accepted = s_rx_axis_tvalid & s_rx_axis_trdy):
  - Not full and drop flag clear: write the entry at wr_ptr and increment wr_ptr.
  - Full, or drop flag set: do not write; set the drop flag.
  - tlast beat, tuser=0, drop flag clear, beat written: commit_ptr <= wr_ptr+1; pulse frame_good next cycle.
  - tlast beat, tuser=1 (drop flag clear): wr_ptr <= commit_ptr; pulse frame_bad.
  - tlast beat with drop flag set or FIFO full: wr_ptr <= commit_ptr; pulse frame_overflow; clear the drop flag.
  - tuser=1 together with overflow: frame_overflow takes priority; only one pulse is raised per frame.
  - A frame longer than DEPTH is always dropped.
- Read side:
  - Memory read is synchronous, followed by a single output register; data is first-word fall-through.
  - When (!m_axis_tvalid | m_axis_trdy) and !empty: read entry rd_ptr, increment rd_ptr, load the output register one cycle later.
  - Read and output-register timing must sustain 1 beat per clock under continuous m_axis_trdy.
  - m_axis_tdata and m_axis_tlast stay stable while m_axis_tvalid & !m_axis_trdy.
- Latency: with the FIFO empty and m_axis_trdy=1, the first byte of a frame is presented exactly 2 cycles after its tlast beat is accepted:
  - edge N: commit;
  - edge N+1: memory read;
  - edge N+2: m_axis_tvalid = 1.
- Concurrency and simultaneous events:
  - Reads see only the registered commit_ptr; there is no same-cycle bypass.
  - Bytes of an uncommitted frame are never popped, so an in-flight frame's space is never freed by reads.
  - Write and read may occur in the same cycle; full is evaluated using the current rd_ptr.
- Ordering: frames leave in arrival order; no gaps are inserted between committed beats when trdy is high.

Test Plan:
- Good frame: 64-byte frame 0x00..0x3F, tuser=0, m_axis_trdy=1 -> 64 identical bytes out; tlast only on 0x3F; frame_good pulses once; first m_axis_tvalid 2 cycles after the tlast beat.
- Bad then good: 60-byte frame with tuser=1 on tlast, then a 60-byte frame of 0xA5 with tuser=0 -> only the 0xA5 frame appears; frame_bad=1 once, then frame_good=1 once.
- Overflow: DEPTH=64, m_axis_trdy=0, 100-byte frame -> frame_overflow pulse, nothing output. A following 40-byte frame is committed and, after trdy=1, delivered intact.
- Exact fill: DEPTH=64, m_axis_trdy=0.
  - 64-byte frame -> frame_good.
  - After draining, a 65-byte frame -> frame_overflow, zero output bytes.
- Backpressure: two back-to-back 64-byte frames while m_axis_trdy toggles pseudo-randomly -> byte order and tlast positions correct; data held stable while valid & !trdy; 128 bytes total.
- Reset mid-frame: assert reset at byte 20 of a 64-byte frame -> all outputs 0 immediately. After release a new 32-byte frame passes cleanly with no residual bytes.

Source files
------------

// File: rtl/rx_mac_frame_fifo.sv
// Store-and-forward receive frame FIFO sitting directly behind rx_mac.
// Beats are written speculatively past commit_ptr; a frame becomes visible
// to the reader only when its final beat arrives clean and the whole frame
// fit. Errored (tuser) or oversize frames rewind wr_ptr to commit_ptr, so
// the consumer only ever sees complete good frames.
//
// Handshake semantics (both interfaces): a beat transfers on a rising clk
// edge where valid and ready are both high. A master holds data/last stable
// while valid is high and ready is low. The slave port here never
// deasserts ready after reset; overflow is absorbed by dropping the frame.
module rx_mac_frame_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_rx_axis_tdata,
  input  logic                  s_rx_axis_tvalid,
  input  logic                  s_rx_axis_tuser,
  input  logic                  s_rx_axis_tlast,
  output logic                  s_rx_axis_trdy,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_trdy,
  output logic                  frame_good,
  output logic                  frame_bad,
  output logic                  frame_overflow
);

  localparam int PTR_W   = ADDR_WIDTH + 1;
  localparam int ENTRY_W = DATA_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = PTR_W'(DEPTH);

  // Storage: each entry is {tlast, tdata}.
  logic [ENTRY_W-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] commit_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;

  // Set once a beat of the current frame could not be stored.
  logic drop;

  logic rx_ready;

  // Read pipeline: synchronous memory read stage, then the output register.
  logic [ENTRY_W-1:0] mem_q;
  logic               mem_q_valid;

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_valid;

  logic good_q;
  logic bad_q;
  logic ovf_q;

  logic full;
  logic empty;
  logic beat;
  logic wr_en;
  logic out_load;
  logic rd_en;

  // Occupancy counts uncommitted bytes too, since they hold real slots.
  assign full  = (wr_ptr - rd_ptr) == DEPTH_CNT;
  // Reader only sees committed data; no bypass from the write side.
  assign empty = (rd_ptr == commit_ptr);

  assign beat  = s_rx_axis_tvalid & rx_ready;
  assign wr_en = beat & ~full & ~drop;

  // Output register takes the read-stage word whenever it is free or being
  // consumed this cycle; this keeps data stable under backpressure.
  assign out_load = mem_q_valid & (~out_valid | m_axis_trdy);

  // Issue a memory read whenever the read stage will be empty next cycle,
  // which lets the pipeline stream one beat per clock.
  assign rd_en = ~empty & (~mem_q_valid | out_load);

  assign s_rx_axis_trdy = rx_ready;
  assign m_axis_tdata   = out_data;
  assign m_axis_tlast   = out_last;
  assign m_axis_tvalid  = out_valid;
  assign frame_good     = good_q;
  assign frame_bad      = bad_q;
  assign frame_overflow = ovf_q;

  // Ready is held low during reset and rises on the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ready <= 1'b0;
    end else begin
      rx_ready <= 1'b1;
    end
  end

  // Write-side pointer bookkeeping: advance, commit, or roll back per frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      drop       <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      good_q <= 1'b0;
      bad_q  <= 1'b0;
      ovf_q  <= 1'b0;
      if (beat) begin
        if (s_rx_axis_tlast) begin
          if (drop | full) begin
            // Frame did not fit; overflow wins over a simultaneous tuser.
            wr_ptr <= commit_ptr;
            drop   <= 1'b0;
            ovf_q  <= 1'b1;
          end else if (s_rx_axis_tuser) begin
            wr_ptr <= commit_ptr;
            bad_q  <= 1'b1;
          end else begin
            wr_ptr     <= wr_ptr + PTR_ONE;
            commit_ptr <= wr_ptr + PTR_ONE;
            good_q     <= 1'b1;
          end
        end else if (wr_en) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end else begin
          drop <= 1'b1;
        end
      end
    end
  end

  // Memory write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_rx_axis_tlast, s_rx_axis_tdata};
    end
  end

  // Synchronous memory read into the read stage register.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      mem_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

  // Read pointer and read-stage occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr      <= '0;
      mem_q_valid <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_ptr      <= rd_ptr + PTR_ONE;
        mem_q_valid <= 1'b1;
      end else if (out_load) begin
        mem_q_valid <= 1'b0;
      end
    end
  end

  // Output register: load from the read stage, clear valid once consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (out_load) begin
        out_data  <= mem_q[DATA_WIDTH-1:0];
        out_last  <= mem_q[DATA_WIDTH];
        out_valid <= 1'b1;
      end else if (m_axis_trdy) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
